// File: rtl/ms_flood.sv
// ms_flood: flood-fill open controller for the 8x8 minesweeper pool.
// A click seeds the clicked cell, then the controller keeps driving the check
// mask (neighbours of open zero cells) into the external pool-update stage and
// latches its open_next every cycle until it reports nothing left to open.
//
// Ports
//   clk, rst_n      clock, async active-low reset
//   clear           sync new game: open/boom cleared, FSM -> IDLE (beats start)
//   start, cursor   click request (sampled in IDLE) and clicked cell index
//   mine/flag/doubt board maps (mine stable during a fill)
//   upd_check       check mask to the update stage (registered-state only)
//   upd_open_next   open map returned by the update stage
//   upd_can_update  update stage still has cells to open
//   open            registered open map
//   busy, done      FSM != IDLE; one-cycle pulse at end of click
//   boom            sticky mine hit
//   iter_cnt        cycles of the last fill in which open changed
module ms_flood #(
  parameter int ROWS = 8,
  parameter int COLS = 8   // ROWS*COLS must be 64 to match the update stage
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clear,
  input  logic        start,
  input  logic [5:0]  cursor,
  input  logic [63:0] mine,
  input  logic [63:0] flag,
  input  logic [63:0] doubt,
  output logic [63:0] upd_check,
  input  logic [63:0] upd_open_next,
  input  logic        upd_can_update,
  output logic [63:0] open,
  output logic        busy,
  output logic        done,
  output logic        boom,
  output logic [6:0]  iter_cnt
);

  typedef enum logic [1:0] {IDLE, SEED, EXPAND, DONE} state_t;

  state_t      state, state_d;
  logic [63:0] open_d;
  logic        boom_d;
  logic [6:0]  iter_d;
  logic [63:0] zero, cur_oh, open_zero_spread;

  // OR of m moved onto each of the 8 neighbours, no wrap at board edges.
  function automatic logic [63:0] spread(input logic [63:0] m);
    logic [63:0] s;
    s = '0;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        for (int dr = -1; dr <= 1; dr++)
          for (int dc = -1; dc <= 1; dc++)
            if ((dr != 0 || dc != 0) && (r + dr >= 0) && (r + dr < ROWS) &&
                (c + dc >= 0) && (c + dc < COLS))
              s[r*COLS + c] = s[r*COLS + c] | m[(r+dr)*COLS + c + dc];
    return s;
  endfunction

  assign cur_oh           = 64'd1 << cursor;
  assign zero             = ~mine & ~spread(mine);
  assign open_zero_spread = spread(open & zero);

  assign busy = (state != IDLE);
  assign done = (state == DONE);

  // Check mask depends only on registered state/open, cursor and mine, so the
  // update stage's outputs never loop back into it combinationally.
  always_comb begin
    upd_check = '0;
    case (state)
      SEED:    upd_check = cur_oh;
      EXPAND:  upd_check = open_zero_spread;
      default: upd_check = '0;
    endcase
  end

  always_comb begin
    state_d = state;
    open_d  = open;
    boom_d  = boom;
    iter_d  = iter_cnt;
    if (clear) begin
      state_d = IDLE;
      open_d  = '0;
      boom_d  = 1'b0;
    end else begin
      case (state)
        IDLE: if (start && !boom) begin
          // Already open, flagged or doubted: nothing to do, just pulse done.
          if (|((open | flag | doubt) & cur_oh)) begin
            state_d = DONE;
          end else begin
            iter_d  = '0;
            state_d = SEED;
          end
        end
        SEED: begin
          open_d = upd_open_next;
          iter_d = 7'd1;
          if (|(mine & cur_oh)) begin
            boom_d  = 1'b1;
            state_d = DONE;
          end else if (|(zero & cur_oh)) begin
            state_d = EXPAND;
          end else begin
            state_d = DONE;
          end
        end
        EXPAND: begin
          // Each accepted update opens at least one cell, so iter_cnt <= 64.
          if (upd_can_update) begin
            open_d = upd_open_next;
            iter_d = iter_cnt + 7'd1;
          end else begin
            state_d = DONE;
          end
        end
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      open     <= '0;
      boom     <= 1'b0;
      iter_cnt <= '0;
    end else begin
      state    <= state_d;
      open     <= open_d;
      boom     <= boom_d;
      iter_cnt <= iter_d;
    end
  end

endmodule

// File: tb/tb_ms_flood.sv
module tb_ms_flood;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        clear = 1'b0;
  logic        start = 1'b0;
  logic [5:0]  cursor = '0;
  logic [63:0] mine = '0, flag = '0, doubt = '0;
  logic [63:0] upd_check, upd_open_next, open;
  logic        upd_can_update, busy, done, boom;
  logic [6:0]  iter_cnt;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  // Behavioural pool-update stage: opens checked cells that are not flagged
  // or doubted, and reports whether anything new would open.
  assign upd_open_next  = open | (upd_check & ~flag & ~doubt);
  assign upd_can_update = |(upd_check & ~open & ~flag & ~doubt);

  ms_flood dut (
    .clk(clk), .rst_n(rst_n), .clear(clear), .start(start), .cursor(cursor),
    .mine(mine), .flag(flag), .doubt(doubt), .upd_check(upd_check),
    .upd_open_next(upd_open_next), .upd_can_update(upd_can_update),
    .open(open), .busy(busy), .done(done), .boom(boom), .iter_cnt(iter_cnt)
  );

  // Pulse start for one edge, then count edges (start edge = 1) until done.
  task automatic click(input logic [5:0] cur, input int maxc,
                       output int cyc, output bit seen);
    @(negedge clk);
    cursor = cur;
    start  = 1'b1;
    cyc    = 0;
    seen   = 1'b0;
    for (int k = 0; k < maxc && !seen; k++) begin
      @(posedge clk); #1;
      start = 1'b0;
      cyc++;
      if (done) seen = 1'b1;
    end
    start = 1'b0;
  endtask

  task automatic new_game();
    @(negedge clk);
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    mine = '0; flag = '0; doubt = '0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (open !== 64'd0)     begin failures++; $display("FAIL reset_open got=%h exp=0", open); end
    checks++; if (busy !== 1'b0)      begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (done !== 1'b0)      begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
    checks++; if (boom !== 1'b0)      begin failures++; $display("FAIL reset_boom got=%b exp=0", boom); end
    checks++; if (iter_cnt !== 7'd0)  begin failures++; $display("FAIL reset_iter got=%0d exp=0", iter_cnt); end
    checks++; if (upd_check !== 64'd0) begin failures++; $display("FAIL reset_check got=%h exp=0", upd_check); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_full_fill();
    int cyc; bit seen;
    new_game();
    click(6'd0, 40, cyc, seen);
    checks++; if (!seen)     begin failures++; $display("FAIL full_done_seen got=0 exp=1"); end
    checks++; if (cyc != 10) begin failures++; $display("FAIL full_cycles got=%0d exp=10", cyc); end
    checks++; if (open !== 64'hFFFF_FFFF_FFFF_FFFF) begin failures++; $display("FAIL full_open got=%h exp=ffffffffffffffff", open); end
    checks++; if (iter_cnt !== 7'd8) begin failures++; $display("FAIL full_iter got=%0d exp=8", iter_cnt); end
    checks++; if (boom !== 1'b0)     begin failures++; $display("FAIL full_boom got=%b exp=0", boom); end
    @(posedge clk); #1;
    checks++; if (done !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL full_pulse done=%b busy=%b exp 0/0", done, busy); end
  endtask

  task automatic test_mine_hit();
    int cyc; bit seen;
    new_game();
    mine = 64'h200;
    click(6'd9, 20, cyc, seen);
    checks++; if (!seen) begin failures++; $display("FAIL boom_done_seen got=0 exp=1"); end
    checks++; if (open !== 64'h200) begin failures++; $display("FAIL boom_open got=%h exp=200", open); end
    checks++; if (boom !== 1'b1)    begin failures++; $display("FAIL boom_flag got=%b exp=1", boom); end
    // A further click while boom is set is ignored.
    click(6'd20, 4, cyc, seen);
    checks++; if (busy !== 1'b0 || seen) begin failures++; $display("FAIL boom_ignore busy=%b done_seen=%b exp 0/0", busy, seen); end
    checks++; if (open !== 64'h200) begin failures++; $display("FAIL boom_ignore_open got=%h exp=200", open); end
    new_game();
    checks++; if (boom !== 1'b0 || open !== 64'd0) begin failures++; $display("FAIL clear_boom boom=%b open=%h exp 0/0", boom, open); end
  endtask

  task automatic test_corner_mine();
    int cyc; bit seen;
    new_game();
    mine = 64'h8000_0000_0000_0000;
    click(6'd0, 40, cyc, seen);
    checks++; if (open !== 64'h7FFF_FFFF_FFFF_FFFF) begin failures++; $display("FAIL corner_open got=%h exp=7fffffffffffffff", open); end
    checks++; if (open[63] !== 1'b0 || open[54] !== 1'b1 || open[55] !== 1'b1 || open[62] !== 1'b1)
      begin failures++; $display("FAIL corner_bits b63=%b b54=%b b55=%b b62=%b exp 0111", open[63], open[54], open[55], open[62]); end
    checks++; if (iter_cnt !== 7'd8) begin failures++; $display("FAIL corner_iter got=%0d exp=8", iter_cnt); end
    checks++; if (boom !== 1'b0)     begin failures++; $display("FAIL corner_boom got=%b exp=0", boom); end
  endtask

  task automatic test_flag_click();
    int cyc; bit seen;
    new_game();
    flag = 64'h20;
    click(6'd5, 10, cyc, seen);
    checks++; if (!seen || cyc != 1) begin failures++; $display("FAIL flag_click seen=%b cyc=%0d exp 1/1", seen, cyc); end
    checks++; if (open !== 64'd0)    begin failures++; $display("FAIL flag_open got=%h exp=0", open); end
    @(posedge clk); #1;
    checks++; if (done !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL flag_pulse done=%b busy=%b exp 0/0", done, busy); end
  endtask

  task automatic test_flag_wall();
    int cyc; bit seen;
    new_game();
    flag = 64'h0808_0808_0808_0808;
    click(6'd0, 40, cyc, seen);
    checks++; if (open !== 64'h0707_0707_0707_0707) begin failures++; $display("FAIL wall_open got=%h exp=0707070707070707", open); end
    checks++; if (iter_cnt !== 7'd8) begin failures++; $display("FAIL wall_iter got=%0d exp=8", iter_cnt); end
  endtask

  task automatic test_abort_reset();
    bit saw_done = 1'b0;
    new_game();
    @(negedge clk); cursor = 6'd0; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    checks++; if (busy !== 1'b1 || open === 64'd0) begin failures++; $display("FAIL rst_pre busy=%b open=%h exp busy=1 open!=0", busy, open); end
    rst_n = 1'b0;
    #1;
    checks++; if (open !== 64'd0 || busy !== 1'b0) begin failures++; $display("FAIL rst_async open=%h busy=%b exp 0/0", open, busy); end
    @(negedge clk); rst_n = 1'b1;
    for (int k = 0; k < 5; k++) begin @(posedge clk); #1; if (done) saw_done = 1'b1; end
    checks++; if (saw_done) begin failures++; $display("FAIL rst_no_done got=1 exp=0"); end
  endtask

  task automatic test_abort_clear();
    bit saw_done = 1'b0;
    new_game();
    @(negedge clk); cursor = 6'd0; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    clear = 1'b1;
    checks++; if (busy !== 1'b1 || open === 64'd0) begin failures++; $display("FAIL clr_pre busy=%b open=%h exp busy=1 open!=0", busy, open); end
    @(posedge clk); #1;
    clear = 1'b0;
    checks++; if (open !== 64'd0 || busy !== 1'b0) begin failures++; $display("FAIL clr_abort open=%h busy=%b exp 0/0", open, busy); end
    for (int k = 0; k < 5; k++) begin if (done) saw_done = 1'b1; @(posedge clk); #1; end
    checks++; if (saw_done) begin failures++; $display("FAIL clr_no_done got=1 exp=0"); end
  endtask

  task automatic test_clear_vs_start();
    new_game();
    @(negedge clk); cursor = 6'd0; start = 1'b1; clear = 1'b1;
    @(posedge clk); #1; start = 1'b0; clear = 1'b0;
    checks++; if (busy !== 1'b0 || open !== 64'd0) begin failures++; $display("FAIL clr_start busy=%b open=%h exp 0/0", busy, open); end
  endtask

  initial begin
    test_reset();
    test_full_fill();
    test_mine_hit();
    test_corner_mine();
    test_flag_click();
    test_flag_wall();
    test_abort_reset();
    test_abort_clear();
    test_clear_vs_start();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
